// File: rtl/rst_seq_ctrl_if.sv
// Reset-sequencer signal bundle: PLL lock and soft-request inputs, PLL/domain reset and status outputs.
// master = sequencer side, slave = the PLL/SoC side that consumes the resets.
interface rst_seq_ctrl_if #(
  parameter int NUM_DOM = 4
);
  logic               pll_locked;
  logic               soft_rst_req;
  logic               pll_areset;
  logic [NUM_DOM-1:0] dom_rst_n;
  logic               rst_done;
  logic [2:0]         seq_state;

  modport master (
    input  pll_locked, soft_rst_req,
    output pll_areset, dom_rst_n, rst_done, seq_state
  );

  modport slave (
    output pll_locked, soft_rst_req,
    input  pll_areset, dom_rst_n, rst_done, seq_state
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Power-on reset sequencer: PLL reset pulse, lock wait, hold, staged domain release; lock timeout retry under RST_SEQ_LOCK_TIMEOUT_EN.
// Latency: lock changes act SYNC_STAGES+1 edges after pll_locked moves; soft_rst_req acts next edge; no backpressure.
module rst_seq_ctrl #(
  parameter int NUM_DOM        = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 8,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGE_GAP      = 4,
  parameter int LOCK_TIMEOUT   = 1000
) (
  input  logic          ext_clk,
  input  logic          ext_rst_n,
  rst_seq_ctrl_if.master sif
);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    HOLD      = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  // One shared counter, sized for the longest programmable interval.
  localparam int MAX_A = (PLL_RST_CYCLES > HOLD_CYCLES) ? PLL_RST_CYCLES : HOLD_CYCLES;
  localparam int MAX_B = (STAGE_GAP > LOCK_TIMEOUT) ? STAGE_GAP : LOCK_TIMEOUT;
  localparam int CNT_W = $clog2(((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1);

  localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
`endif

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   int_rst_n;
  logic                   lock_s;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [NUM_DOM-1:0] dom_q, dom_d;
  logic               pll_areset_q, pll_areset_d;

  always_ff @(posedge ext_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      rst_sync_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], sif.pll_locked};
    end
  end

  assign int_rst_n = rst_sync_q[SYNC_STAGES-1];
  assign lock_s    = lock_sync_q[SYNC_STAGES-1];
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    dom_d   = dom_q;
    unique case (state_q)
      PLL_RST: begin
        dom_d = '0;
        if (cnt_q >= PLL_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        dom_d = '0;
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
        if (lock_s) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q >= TO_LAST) begin
          state_d = PLL_RST;
          cnt_d   = '0;
        end
`else
        cnt_d = '0;
        if (lock_s) state_d = HOLD;
`endif
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          dom_d   = '0;
        end else if (cnt_q >= HOLD_LAST) begin
          cnt_d   = '0;
          dom_d   = NUM_DOM'(1);
          state_d = (NUM_DOM == 1) ? RUN : RELEASE;
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          dom_d   = '0;
        end else if (cnt_q >= GAP_LAST) begin
          cnt_d = '0;
          dom_d = (dom_q << 1) | NUM_DOM'(1);
          if (&dom_d) state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = '0;
        // Lock loss is tested first so it overrides a simultaneous soft request.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          dom_d   = '0;
        end else if (sif.soft_rst_req) begin
          state_d = HOLD;
          dom_d   = '0;
        end
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
        dom_d   = '0;
      end
    endcase
    pll_areset_d = (state_d == PLL_RST);
  end

  always_ff @(posedge ext_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      dom_q        <= '0;
      pll_areset_q <= 1'b1;
    end else if (!int_rst_n) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      dom_q        <= '0;
      pll_areset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dom_q        <= dom_d;
      pll_areset_q <= pll_areset_d;
    end
  end

  assign sif.pll_areset = pll_areset_q;
  assign sif.dom_rst_n  = dom_q;
  assign sif.rst_done   = (state_q == RUN);
  assign sif.seq_state  = state_q;

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter NUM_DOM, default 4: number of reset domains released in sequence, range 1..8.
REQ-002 Parameter SYNC_STAGES, default 2: flop depth of the pll_locked and ext_rst_n synchronisers, range 2..4.
REQ-003 Parameter PLL_RST_CYCLES, default 8: cycles pll_areset is held high per PLL reset pulse, range 1..255.
REQ-004 Parameter HOLD_CYCLES, default 16: cycles of stable lock required before the first domain release, range 1..65535.
REQ-005 Parameter STAGE_GAP, default 4: cycles between consecutive domain releases, range 1..255.
REQ-006 Parameter LOCK_TIMEOUT, default 1000: WAIT_LOCK cycle limit, used only with RST_SEQ_LOCK_TIMEOUT_EN, range 1..65535.
REQ-007 ext_clk  input  1  sole clock, rising-edge; all logic runs in this single clock domain.
REQ-008 ext_rst_n  input  1  asynchronous active-low reset.
REQ-009 pll_locked  input  1  PLL lock flag, asynchronous to ext_clk.
REQ-010 soft_rst_req  input  1  synchronous one-cycle request to re-reset all domains without a PLL reset.
REQ-011 pll_areset  output  1  active-high PLL reset, registered.
REQ-012 dom_rst_n  output  NUM_DOM  active-low domain resets, registered; bit 0 is released first.
REQ-013 rst_done  output  1  high only in RUN.
REQ-014 seq_state  output  3  current FSM state encoding: PLL_RST=0, WAIT_LOCK=1, HOLD=2, RELEASE=3, RUN=4.

Function
REQ-015 pll_locked SHALL pass through SYNC_STAGES flops; only the synchronised lock_s SHALL be used.
REQ-016 PLL_RST: pll_areset=1 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK with pll_areset=0.
REQ-017 WAIT_LOCK: lock_s=1 -> HOLD with hold counter cleared.
REQ-018 HOLD: counter increments per cycle with lock_s=1; on reaching HOLD_CYCLES -> RELEASE.
REQ-019 RELEASE: dom_rst_n[0] rises on the first RELEASE cycle; dom_rst_n[i] rises exactly STAGE_GAP cycles after dom_rst_n[i-1].
REQ-020 The cycle dom_rst_n[NUM_DOM-1] rises the FSM SHALL enter RUN; rst_done rises in that same cycle.
REQ-021 lock_s=0 in HOLD, RELEASE or RUN: all dom_rst_n=0 and rst_done=0 on the next edge, state -> WAIT_LOCK.
REQ-022 soft_rst_req=1 in RUN: all dom_rst_n=0 next edge, state -> HOLD (no PLL reset); ignored in other states.
REQ-023 Lock loss and soft_rst_req in the same cycle: lock loss wins.
REQ-024 Released bits SHALL never deassert out of order; no dom_rst_n bit rises outside RELEASE.
REQ-025 Counters SHALL saturate, never wrap; NUM_DOM=1 -> RUN on the first RELEASE cycle.

Reset
REQ-026 ext_rst_n low SHALL asynchronously force: state PLL_RST, pll_areset=1, dom_rst_n=0, rst_done=0, counters 0.
REQ-027 Deassertion SHALL be synchronised: internal reset releases SYNC_STAGES edges after ext_rst_n rises; the PLL_RST count starts then.
REQ-028 ext_rst_n asserted mid-RELEASE or RUN SHALL drop all outputs to reset values within the same cycle.

Configuration
REQ-029 Macro RST_SEQ_LOCK_TIMEOUT_EN defined: WAIT_LOCK exceeding LOCK_TIMEOUT cycles SHALL return to PLL_RST and re-pulse pll_areset, retrying indefinitely.
REQ-030 RST_SEQ_LOCK_TIMEOUT_EN undefined: WAIT_LOCK waits indefinitely; no timeout counter is present.

Verification (NUM_DOM=4, SYNC_STAGES=2, PLL_RST_CYCLES=8, HOLD_CYCLES=16, STAGE_GAP=4, LOCK_TIMEOUT=1000)
REQ-031 Cold start, pll_locked rises 20 cycles after ext_rst_n -> pll_areset high 8 cycles; dom_rst_n 0001,0011,0111,1111 at 4-cycle spacing; rst_done with 1111.
REQ-032 pll_locked drops 5 cycles for RUN -> dom_rst_n=0000 next edge, WAIT_LOCK, full HOLD+RELEASE repeated, no PLL reset.
REQ-033 soft_rst_req pulse in RUN -> dom_rst_n=0000, seq_state=2, 16-cycle hold then staged release; pll_areset stays 0.
REQ-034 Lock loss and soft_rst_req same cycle -> seq_state=1 (WAIT_LOCK).
REQ-035 ext_rst_n low while dom_rst_n=0011 -> all outputs reset asynchronously; restart from PLL_RST.
REQ-036 Macro defined, pll_locked held 0 -> pll_areset re-pulses every 8+1000 cycles; macro undefined -> single pulse only.
